// File: rtl/wb_timer_bank.sv
// wb_timer_bank: Wishbone slave holding NUM_CH independent prescaled
// up-counters, each with a compare register, one-shot or auto-reload mode,
// a sticky match flag and an interrupt enable. The enabled flags are ORed
// onto a single registered interrupt line.
module wb_timer_bank #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int PRE_WIDTH    = 8
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
  input  logic                    wb_we_i,
  output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    irq_o
);

  localparam int CH_AW = WB_ADR_WIDTH - 4;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_e;

  typedef struct packed {
    logic                 en;
    logic                 reload;
    logic                 ie;
    logic [PRE_WIDTH-1:0] pre;
    logic [PRE_WIDTH-1:0] precnt;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] compare;
    logic                 flag;
  } chan_t;

  chan_t                   ch_q [NUM_CH];
  chan_t                   ch_d [NUM_CH];
  logic                    ack_q, ack_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic                    irq_q, irq_d;

  logic                    req;
  logic                    wr;
  logic [CH_AW-1:0]        ch_idx;
  reg_e                    reg_sel;
  logic [NUM_CH-1:0]       ch_sel;
  logic [NUM_CH-1:0]       tick;
  logic [WB_DAT_WIDTH-1:0] rd_data;

  // Byte-lane bits and write data above the register widths carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  // A new request is only taken while no ack is outstanding, so every
  // access occupies exactly two cycles.
  assign req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr      = req & wb_we_i;
  assign ch_idx  = wb_adr_i[WB_ADR_WIDTH-1:4];
  assign reg_sel = reg_e'(wb_adr_i[3:2]);

  // Channel select and prescaler tick; an unmapped index selects nothing.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_sel[c] = (ch_idx == CH_AW'(c));
      tick[c]   = ch_q[c].en && (ch_q[c].precnt == ch_q[c].pre);
    end
  end

  // Per-channel next state: prescaler, tick/compare action, then bus writes.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      // NOTE: start from the held value so every path assigns ch_d and no latch is inferred.
      ch_d[c] = ch_q[c];

      if (ch_q[c].en) begin
        ch_d[c].precnt = tick[c] ? '0 : ch_q[c].precnt + PRE_WIDTH'(1);
      end

      // The clear comes before the tick so a match on the same edge keeps the flag set.
      if (wr && ch_sel[c] && (reg_sel == REG_STATUS) && wb_dat_i[0]) begin
        ch_d[c].flag = 1'b0;
      end

      if (tick[c]) begin
        if (ch_q[c].count == ch_q[c].compare) begin
          ch_d[c].flag = 1'b1;
          if (ch_q[c].reload) begin
            ch_d[c].count = '0;
          end else begin
            ch_d[c].en = 1'b0;
          end
        end else begin
          ch_d[c].count = ch_q[c].count + CNT_WIDTH'(1);
        end
      end

      // Bus writes come last so they override the tick's update of the same register.
      if (wr && ch_sel[c]) begin
        case (reg_sel)
          REG_CTRL: begin
            ch_d[c].en     = wb_dat_i[0];
            ch_d[c].reload = wb_dat_i[1];
            ch_d[c].ie     = wb_dat_i[2];
            ch_d[c].pre    = wb_dat_i[8 +: PRE_WIDTH];
            if (!ch_q[c].en && wb_dat_i[0]) begin
              ch_d[c].precnt = '0;
            end
          end
          REG_COUNT: begin
            ch_d[c].count  = wb_dat_i[CNT_WIDTH-1:0];
            ch_d[c].precnt = '0;
          end
          REG_COMPARE: ch_d[c].compare = wb_dat_i[CNT_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux; unmapped channels and unused bits read as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel[c]) begin
        case (reg_sel)
          REG_CTRL: begin
            rd_data[0]              = ch_q[c].en;
            rd_data[1]              = ch_q[c].reload;
            rd_data[2]              = ch_q[c].ie;
            rd_data[8 +: PRE_WIDTH] = ch_q[c].pre;
          end
          REG_COUNT:   rd_data[CNT_WIDTH-1:0] = ch_q[c].count;
          REG_COMPARE: rd_data[CNT_WIDTH-1:0] = ch_q[c].compare;
          default:     rd_data[0]             = ch_q[c].flag;
        endcase
      end
    end
  end

  // Bus response and interrupt aggregation.
  always_comb begin
    ack_d = req;
    dat_d = (req && !wb_we_i) ? rd_data : dat_q;
    irq_d = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq_d = irq_d | (ch_q[c].flag & ch_q[c].ie);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
      // NOTE: the channel array is a handful of flops, not a RAM, so it is safe and required to reset it.
      for (int c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so all flops sample the pre-edge values.
      ack_q <= ack_d;
      dat_q <= dat_d;
      irq_q <= irq_d;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= ch_d[c];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer_bank.sv
// tb_wb_timer_bank: directed and randomized Wishbone traffic against
// wb_timer_bank, checked every cycle against a behavioural model of the
// timer bank plus literal expectations for the key scenarios.
module tb_wb_timer_bank;

  localparam int NCH = 4;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [7:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  wb_timer_bank #(
    .WB_ADR_WIDTH(8),
    .WB_DAT_WIDTH(32),
    .NUM_CH      (NCH),
    .CNT_WIDTH   (32),
    .PRE_WIDTH   (8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_stb_i(stb),
    .wb_cyc_i(cyc),
    .wb_adr_i(adr),
    .wb_dat_i(dat_i),
    .wb_we_i (we),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_en     [NCH];
  bit          m_rl     [NCH];
  bit          m_ie     [NCH];
  int          m_pre    [NCH];
  int          m_since  [NCH]; // clocks elapsed since the last tick while enabled
  logic [31:0] m_count  [NCH];
  logic [31:0] m_cmp    [NCH];
  bit          m_flag   [NCH];
  bit          m_ack = 1'b0;
  bit          m_irq = 1'b0;
  logic [31:0] m_dat = 32'h0;

  function automatic logic [31:0] model_read(input int ch, input int rg);
    if (ch >= NCH) return 32'h0;
    case (rg)
      0: return (32'(m_pre[ch]) << 8) | (32'(m_ie[ch]) << 2) | (32'(m_rl[ch]) << 1) | 32'(m_en[ch]);
      1: return m_count[ch];
      2: return m_cmp[ch];
      default: return 32'(m_flag[ch]);
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit req;
    bit irq_n;
    int ch;
    int rg;
    bit was_en [NCH];
    bit set_now [NCH];
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_en[i] = 0; m_rl[i] = 0; m_ie[i] = 0; m_pre[i] = 0; m_since[i] = 0;
        m_count[i] = 0; m_cmp[i] = 0; m_flag[i] = 0;
      end
      m_ack = 0; m_irq = 0; m_dat = 0;
    end else begin
      irq_n = 0;
      for (int i = 0; i < NCH; i++) irq_n = irq_n | (m_flag[i] & m_ie[i]);
      req = stb && cyc && !m_ack;
      ch  = int'(adr[7:4]);
      rg  = int'(adr[3:2]);
      if (req && !we) m_dat = model_read(ch, rg);
      for (int i = 0; i < NCH; i++) begin
        was_en[i]  = m_en[i];
        set_now[i] = 0;
        if (m_en[i]) begin
          if (m_since[i] == m_pre[i]) begin
            m_since[i] = 0;
            if (m_count[i] == m_cmp[i]) begin
              m_flag[i]  = 1;
              set_now[i] = 1;
              if (m_rl[i]) m_count[i] = 0;
              else         m_en[i] = 0;
            end else begin
              m_count[i] = m_count[i] + 32'd1;
            end
          end else begin
            m_since[i] = m_since[i] + 1;
          end
        end
      end
      if (req && we && ch < NCH) begin
        case (rg)
          0: begin
            m_en[ch]  = dat_i[0];
            m_rl[ch]  = dat_i[1];
            m_ie[ch]  = dat_i[2];
            m_pre[ch] = int'(dat_i[15:8]);
            if (!was_en[ch] && dat_i[0]) m_since[ch] = 0;
          end
          1: begin m_count[ch] = dat_i; m_since[ch] = 0; end
          2: m_cmp[ch] = dat_i;
          default: if (dat_i[0] && !set_now[ch]) m_flag[ch] = 0;
        endcase
      end
      m_ack = req;
      m_irq = irq_n;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("ack_vs_model", 32'(ack), 32'(m_ack));
    check("irq_vs_model", 32'(irq), 32'(m_irq));
    check("dat_vs_model", dat_o, m_dat);
  end

  // ---------------- bus access ----------------
  // Called at a negedge; returns at a negedge two cycles later.
  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
    int n;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
    @(posedge clk); #1;
    check("ack_latency", 32'(ack), 32'd1);
    n = 0;
    while (!ack && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    r = dat_o;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'h0, r);
    check(name, r, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] r;
    int          n;
    logic [7:0]  a;
    logic [31:0] d;
    int          rg;

    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = 8'h0; dat_i = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int c = 0; c < NCH; c++)
      for (int g = 0; g < 4; g++)
        rd_check("reset_reg", 8'((c << 4) | (g << 2)), 32'h0);

    // ch0: compare 5, auto-reload, ie, en, pre 0
    wr(8'h08, 32'd5);
    wr(8'h00, 32'h07);
    repeat (20) @(negedge clk);
    check("ch0_irq_set", 32'(irq), 32'd1);
    rd_check("ch0_status_set", 8'h0C, 32'd1);
    wr(8'h00, 32'h06);             // stop ch0, flag stays up
    check("ch0_irq_held", 32'(irq), 32'd1);
    wr(8'h0C, 32'd1);              // W1C
    check("ch0_irq_cleared", 32'(irq), 32'd0);
    rd_check("ch0_status_clr", 8'h0C, 32'd0);

    // ch1: pre 3, compare 2, one-shot
    wr(8'h18, 32'd2);
    wr(8'h10, 32'h0301);
    repeat (40) @(negedge clk);
    rd_check("ch1_ctrl_en_off", 8'h10, 32'h0300);
    rd_check("ch1_count_hold", 8'h14, 32'd2);
    rd_check("ch1_status", 8'h1C, 32'd1);

    // ch2: wrap without flag
    wr(8'h28, 32'h10);
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h20, 32'h01);
    rd_check("ch2_wrap_count", 8'h24, 32'h0);
    rd_check("ch2_wrap_noflag", 8'h2C, 32'h0);

    // COUNT write landing on a tick edge
    wr(8'h20, 32'h0701);
    n = 0;
    while (!(m_en[2] && m_since[2] == m_pre[2]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ch2_tick_align", 32'(n < 20), 32'd1);
    wr(8'h24, 32'h100);
    rd_check("ch2_collision_count", 8'h24, 32'h100);

    // W1C landing on a match edge
    wr(8'h00, 32'h07);
    n = 0;
    while (!(m_en[0] && m_since[0] == m_pre[0] && m_count[0] == m_cmp[0]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ch0_match_align", 32'(n < 30), 32'd1);
    wr(8'h0C, 32'd1);
    rd_check("ch0_w1c_collision", 8'h0C, 32'd1);

    // Unmapped channel
    wr(8'h40, 32'hDEAD);
    rd_check("unmapped_read", 8'h40, 32'h0);
    rd_check("unmapped_read_st", 8'h4F, 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      a  = 8'(($urandom_range(0, 9) == 0 ? $urandom_range(4, 15) : $urandom_range(0, 3)) << 4);
      rg = int'($urandom_range(0, 3));
      a  = a | 8'(rg << 2) | 8'($urandom_range(0, 3));
      case (rg)
        0: d = ($urandom & 32'hFFFF_00F8) | 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 3)) << 8);
        1: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
        2: d = 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      bus($urandom_range(0, 1) == 1, a, d, r);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    // Reset during an open request drops it without ack
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 8'h04; rst = 1'b1;
    @(negedge clk);
    check("reset_drop_ack", 32'(ack), 32'd0);
    stb = 1'b0; cyc = 1'b0; rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      for (int g = 0; g < 4; g++)
        rd_check("post_reset_reg", 8'((c << 4) | (g << 2)), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_timer_bank.md
Name: wb_timer_bank

Overview:
Wishbone-slave bank of NUM_CH independent, prescaled up-counters with per-channel compare, one-shot/auto-reload mode and a match flag. It is the parametrised successor of the single free-running counter slave and adds width and channel generalisation, prescaling, compare matching and an aggregated interrupt. It sits on the chip's internal Wishbone bus as a generic timer/event peripheral.

Parameters:
WB_ADR_WIDTH, 8, Wishbone byte-address width; must be at least 4 + clog2(NUM_CH).
WB_DAT_WIDTH, 32, Wishbone data width.
NUM_CH, 4, number of timer channels (1..16).
CNT_WIDTH, 32, counter/compare width; must be ≤ WB_DAT_WIDTH.
PRE_WIDTH, 8, prescaler width; must be ≤ 8.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous, active-high reset
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  bus cycle
wb_adr_i  in  WB_ADR_WIDTH  byte address
wb_dat_i  in  WB_DAT_WIDTH  write data
wb_we_i   in  1  write enable
wb_dat_o  out WB_DAT_WIDTH  read data, registered
wb_ack_o  out 1  acknowledge, registered
irq_o     out 1  OR over channels of (flag & ie), registered

Behaviour:
- Reset: one clock, synchronous, active-high. Every channel is cleared: count=0, compare=0, ctrl=0, flag=0, prescaler=0. Outputs reset to wb_dat_o=0, wb_ack_o=0, irq_o=0. A reset during an open transaction drops it with no ack.
- Decode: channel = adr[WB_ADR_WIDTH-1:4]; register = adr[3:2]; adr[1:0] is ignored.
- Registers:
  - 0 CTRL: bit0 en, bit1 reload (1 = auto-reload, 0 = one-shot), bit2 ie, bits[8+PRE_WIDTH-1:8] pre.
  - 1 COUNT.
  - 2 COMPARE.
  - 3 STATUS: bit0 flag, write-1-to-clear.
  - Unused bits read 0. Writes truncate to the register width; reads zero-extend.
- Unmapped channel (channel ≥ NUM_CH): reads return 0, writes are ignored, ack is still given.
- Handshake:
  - A request is stb & cyc & ~ack. ack asserts exactly 1 cycle after the request, for 1 cycle. Every access takes 2 cycles; back-to-back requests are accepted every other cycle.
  - On a read, wb_dat_o is loaded in the same edge as ack and holds until the next read.
  - On a write, the register is updated in the same edge as ack.
  - No byte selects, no error or retry.
- Prescaler (per channel): while en=1, precnt increments each clock. When precnt == pre, a tick is generated and precnt returns to 0. pre=0 gives a tick every clock; pre=N gives a tick every N+1 clocks. While en=0, precnt holds.
- On a tick:
  - If count == compare: flag←1. If reload, count←0. Otherwise (one-shot) en←0 and count holds at compare.
  - Else count←count+1, wrapping from 2^CNT_WIDTH−1 to 0 without setting flag.
- A COUNT write, or a CTRL write that changes en from 0 to 1, clears precnt.
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick wins; the tick's update to that register is discarded.
  - A flag set in the same cycle as a W1C write wins (flag stays 1).
  - A COMPARE write takes effect for the next tick.
- irq_o is registered: it asserts 1 cycle after flag&ie becomes true and deasserts 1 cycle after the clear.
- Channels are fully independent apart from the shared bus and the OR onto irq_o.

Test Plan:
- Reset → all outputs 0. Read CTRL, COUNT, COMPARE and STATUS of every channel → 0 each; every access is acked exactly 1 cycle after stb.
- ch0: COMPARE=5, CTRL=0x07 (pre=0, reload, ie, en) → COUNT sequence 0,1,…,5,0. Flag and irq_o set after the 6th tick, irq_o 1 cycle after flag. W1C STATUS=1 → irq_o drops 1 cycle later.
- ch1: pre=3, COMPARE=2, one-shot, en → count increments every 4 clocks; flag set on the 3rd tick; en reads back 0; COUNT holds at 2.
- Wrap: ch2 COUNT=0xFFFF_FFFF, COMPARE=0x10, pre=0, en → next tick gives COUNT=0 and flag stays 0.
- Collision: a COUNT=0x100 write lands on a tick edge → read-back is 0x100. A W1C on the match edge → flag reads 1.
- Unmapped: with NUM_CH=4, write 0xDEAD to address 0x40 → acked, no channel changes; a read of 0x40 returns 0.
